seq_mul_ctrl: RTL

Multi-cycle shift-add multiplier controller for the RV32M multiply group (MUL, MULH, MULHSU, MULHU). It sequences a single 2N-bit ripple-carry add step over N cycles rather than building an array multiplier. Operands are converted to magnitudes and the sign is fixed at the end. It sits beside the ALU in EX and stalls the pipeline through a start/busy/done handshake.

---
 rtl/mul_pkg.sv | 30 +++
 rtl/full_adder.sv | 13 +
 rtl/mul_add_step.sv | 27 ++
 rtl/seq_mul_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential RV32M multiplier controller.
package mul_pkg;

  localparam int MUL_N     = 32;
  localparam int MUL_CNT_W = $clog2(MUL_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_t;

  // rs1 is signed for every op except MULHU; rs2 only for MUL and MULH.
  function automatic logic op_a_signed(input op_t op);
    return op != OP_MULHU;
  endfunction

  function automatic logic op_b_signed(input op_t op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell used to build the ripple-carry add step.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/mul_add_step.sv
// Combinational W-bit ripple-carry adder; the carry out of the top bit is discarded.
module mul_add_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum
);

  logic [W-1:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < W - 1; i++) begin : g_fa
    full_adder u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  // Top bit has no carry out to produce.
  assign sum[W-1] = x[W-1] ^ y[W-1] ^ c[W-1];

endmodule

// File: rtl/seq_mul_ctrl.sv
// Shift-add multiplier controller for MUL/MULH/MULHSU/MULHU, one add step per cycle.
// Optional macro SEQ_MUL_EARLY_EXIT_EN: leave CALC as soon as the remaining multiplier is zero.
module seq_mul_ctrl
  import mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [MUL_N-1:0]   a,
  input  logic [MUL_N-1:0]   b,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [MUL_N-1:0]   result
);

  localparam int N = MUL_N;

  state_t               state_q, state_d;
  op_t                  op_q;
  logic                 neg_q;
  logic [2*N-1:0]       acc_q, mcand_q, sum, acc_fin;
  logic [N-1:0]         mplier_q, a_mag, b_mag;
  logic [MUL_CNT_W-1:0] cnt_q;
  logic                 sa, sb, accept, last_step;

  mul_add_step #(.W(2*N)) u_add (
    .x   (acc_q),
    .y   (mcand_q),
    .sum (sum)
  );

  assign sa     = op_a_signed(op_t'(op)) & a[N-1];
  assign sb     = op_b_signed(op_t'(op)) & b[N-1];
  assign a_mag  = sa ? -a : a;
  assign b_mag  = sb ? -b : b;
  assign accept = (state_q == IDLE) && start && !flush;

`ifdef SEQ_MUL_EARLY_EXIT_EN
  assign last_step = (mplier_q[N-1:1] == '0) || (cnt_q == MUL_CNT_W'(N - 1));
`else
  assign last_step = (cnt_q == MUL_CNT_W'(N - 1));
`endif

  assign acc_fin = neg_q ? -acc_q : acc_q;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_step) state_d = SIGN;
      SIGN:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == CALC) || (state_d == SIGN);
      done    <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result   <= '0;
    end else if (accept) begin
      op_q     <= op_t'(op);
      neg_q    <= sa ^ sb;
      acc_q    <= '0;
      mcand_q  <= {{N{1'b0}}, a_mag};
      mplier_q <= b_mag;
      cnt_q    <= '0;
    end else if (!flush) begin
      // A flushed operation leaves result untouched; stale datapath is reloaded on accept.
      case (state_q)
        CALC: begin
          if (mplier_q[0]) acc_q <= sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + MUL_CNT_W'(1);
        end
        SIGN: begin
          acc_q  <= acc_fin;
          result <= (op_q == OP_MUL) ? acc_fin[N-1:0] : acc_fin[2*N-1:N];
        end
        default: ;
      endcase
    end
  end

endmodule
